// File: rtl/cp0_regfile_if.sv
// Bundle between the CP0 register file and its clients: the pipeline (mtc0/mfc0/eret)
// and the exception controller (exception commit, Status/Cause feedback).
interface cp0_regfile_if;
  // Pipeline side
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_data;
  logic        eret;

  // Exception controller side
  logic        exception;
  logic        we_cause;
  logic        we_epc;
  logic        inc_epc;
  logic [31:0] in_status;
  logic [31:0] in_cause;
  logic [31:0] exc_inst_pc;
  logic        we_badvaddr;
  logic [31:0] bad_vaddr;

  // External interrupt lines
  logic [4:0]  irq;

  // State fed back to the rest of the core
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic [31:0] exc_pc;
  logic        int_pending;
  logic        timer_int;

  modport master (
    output mtc0_we, mtc0_addr, mtc0_data, mfc0_addr, eret,
           exception, we_cause, we_epc, inc_epc, in_status, in_cause,
           exc_inst_pc, we_badvaddr, bad_vaddr, irq,
    input  mfc0_data, status, cause, epc, exc_pc, int_pending, timer_int
  );

  modport slave (
    input  mtc0_we, mtc0_addr, mtc0_data, mfc0_addr, eret,
           exception, we_cause, we_epc, inc_epc, in_status, in_cause,
           exc_inst_pc, we_badvaddr, bad_vaddr, irq,
    output mfc0_data, status, cause, epc, exc_pc, int_pending, timer_int
  );
endinterface

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC,
// the Count/Compare timer and registered sampling of the external IRQ lines.
module cp0_regfile #(
  parameter int unsigned COUNT_DIV  = 1,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input logic          clk,
  input logic          rst,
  cp0_regfile_if.slave bus
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

  logic [31:0] badvaddr, badvaddr_nxt;
  logic [31:0] count,    count_nxt;
  logic [31:0] compare,  compare_nxt;
  logic [31:0] status,   status_nxt;
  logic [31:0] cause,    cause_nxt;
  logic [31:0] epc,      epc_nxt;
  logic [3:0]  div_cnt,  div_cnt_nxt;

  logic        mtc0_ok;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic        tick;
  logic [31:0] count_inc;
  logic        timer_match;

  // An mtc0 only lands when neither an exception nor an eret claims the same edge.
  assign mtc0_ok    = bus.mtc0_we & ~bus.exception & ~bus.eret;
  assign wr_count   = mtc0_ok && (bus.mtc0_addr == REG_COUNT);
  assign wr_compare = mtc0_ok && (bus.mtc0_addr == REG_COMPARE);
  assign wr_status  = mtc0_ok && (bus.mtc0_addr == REG_STATUS);
  assign wr_cause   = mtc0_ok && (bus.mtc0_addr == REG_CAUSE);
  assign wr_epc     = mtc0_ok && (bus.mtc0_addr == REG_EPC);

  assign tick        = (div_cnt == DIV_LAST);
  assign count_inc   = count + 32'd1;
  assign timer_match = tick & ~wr_count & (count_inc == compare);

  // NOTE: every variable assigned in an always_comb gets a default on entry,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    status_nxt = status;
    if (bus.exception)
      status_nxt = bus.in_status;
    else if (bus.eret)
      status_nxt[1] = 1'b0;
    else if (wr_status)
      status_nxt = bus.mtc0_data;
  end

  always_comb begin
    epc_nxt = epc;
    if (bus.exception && bus.we_epc)
      epc_nxt = bus.inc_epc ? bus.exc_inst_pc - 32'd4 : bus.exc_inst_pc;
    else if (wr_epc)
      epc_nxt = bus.mtc0_data;
  end

  always_comb begin
    badvaddr_nxt = badvaddr;
    if (bus.exception && bus.we_badvaddr)
      badvaddr_nxt = bus.bad_vaddr;
  end

  always_comb begin
    compare_nxt = wr_compare ? bus.mtc0_data : compare;
  end

  always_comb begin
    count_nxt   = count;
    div_cnt_nxt = div_cnt + 4'd1;
    if (wr_count) begin
      count_nxt   = bus.mtc0_data;
      div_cnt_nxt = 4'd0;
    end else if (tick) begin
      count_nxt   = count_inc;
      div_cnt_nxt = 4'd0;
    end
  end

  // Bits [15:10] are owned by hardware (timer and IRQ lines) whatever software
  // or the exception controller tries to write there.
  always_comb begin
    cause_nxt = cause;
    if (bus.exception && bus.we_cause)
      cause_nxt = bus.in_cause;
    if (bus.exception && bus.we_epc)
      cause_nxt[31] = bus.inc_epc;
    if (wr_cause)
      cause_nxt[9:8] = bus.mtc0_data[9:8];
    cause_nxt[14:10] = bus.irq;
    cause_nxt[15]    = wr_compare ? 1'b0 : (cause[15] | timer_match);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr <= '0;
      count    <= '0;
      compare  <= 32'hFFFF_FFFF;
      status   <= '0;
      cause    <= '0;
      epc      <= '0;
      div_cnt  <= '0;
    end else begin
      badvaddr <= badvaddr_nxt;
      count    <= count_nxt;
      compare  <= compare_nxt;
      status   <= status_nxt;
      cause    <= cause_nxt;
      epc      <= epc_nxt;
      div_cnt  <= div_cnt_nxt;
    end
  end

  always_comb begin
    unique case (bus.mfc0_addr)
      REG_BADVADDR: bus.mfc0_data = badvaddr;
      REG_COUNT:    bus.mfc0_data = count;
      REG_COMPARE:  bus.mfc0_data = compare;
      REG_STATUS:   bus.mfc0_data = status;
      REG_CAUSE:    bus.mfc0_data = cause;
      REG_EPC:      bus.mfc0_data = epc;
      default:      bus.mfc0_data = '0;
    endcase
  end

  assign bus.status      = status;
  assign bus.cause       = cause;
  assign bus.epc         = epc;
  assign bus.exc_pc      = EXC_VECTOR;
  assign bus.timer_int   = cause[15];
  assign bus.int_pending = status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios plus randomized traffic,
// run on a COUNT_DIV=1 and a COUNT_DIV=3 instance against a register-array model.
module tb_cp0_regfile;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  cp0_regfile_if bus ();
  cp0_regfile_if bus3 ();

  cp0_regfile dut (.clk(clk), .rst(rst), .bus(bus.slave));
  cp0_regfile #(.COUNT_DIV(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  // The divide-by-3 instance sees exactly the same stimulus.
  assign bus3.mtc0_we     = bus.mtc0_we;
  assign bus3.mtc0_addr   = bus.mtc0_addr;
  assign bus3.mtc0_data   = bus.mtc0_data;
  assign bus3.mfc0_addr   = bus.mfc0_addr;
  assign bus3.eret        = bus.eret;
  assign bus3.exception   = bus.exception;
  assign bus3.we_cause    = bus.we_cause;
  assign bus3.we_epc      = bus.we_epc;
  assign bus3.inc_epc     = bus.inc_epc;
  assign bus3.in_status   = bus.in_status;
  assign bus3.in_cause    = bus.in_cause;
  assign bus3.exc_inst_pc = bus.exc_inst_pc;
  assign bus3.we_badvaddr = bus.we_badvaddr;
  assign bus3.bad_vaddr   = bus.bad_vaddr;
  assign bus3.irq         = bus.irq;

  // Reference model: CP0 register array indexed by register number, one per instance.
  logic [31:0] m_reg [2][32];
  int          m_div [2];

  function automatic int div_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] m_read(int k, logic [4:0] a);
    if (a inside {5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14}) return m_reg[k][a];
    return 32'h0;
  endfunction

  function automatic logic m_int(int k);
    logic [31:0] st, ca;
    st = m_reg[k][12];
    ca = m_reg[k][13];
    return st[0] & ~st[1] & (|(ca[15:8] & st[15:8]));
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] r [32];
      int  d;
      logic tick;
      for (int i = 0; i < 32; i++) r[i] = m_reg[k][i];
      if (rst) begin
        for (int i = 0; i < 32; i++) r[i] = 32'h0;
        r[11] = 32'hFFFF_FFFF;
        d = 0;
      end else begin
        tick = (m_div[k] == div_of(k) - 1);
        d = tick ? 0 : m_div[k] + 1;
        if (tick) begin
          r[9] = m_reg[k][9] + 32'd1;
          if (r[9] == m_reg[k][11]) r[13][15] = 1'b1;
        end
        r[13][14:10] = bus.irq;
        if (bus.exception) begin
          r[12] = bus.in_status;
          if (bus.we_cause) r[13] = {bus.in_cause[31:16], r[13][15:10], bus.in_cause[9:0]};
          if (bus.we_epc) begin
            r[14] = bus.inc_epc ? bus.exc_inst_pc - 32'd4 : bus.exc_inst_pc;
            r[13][31] = bus.inc_epc;
          end
          if (bus.we_badvaddr) r[8] = bus.bad_vaddr;
        end else if (bus.eret) begin
          r[12][1] = 1'b0;
        end else if (bus.mtc0_we) begin
          case (bus.mtc0_addr)
            5'd9: begin
              r[9] = bus.mtc0_data;
              d = 0;
              r[13][15] = m_reg[k][13][15];
            end
            5'd11: begin
              r[11] = bus.mtc0_data;
              r[13][15] = 1'b0;
            end
            5'd12: r[12] = bus.mtc0_data;
            5'd13: r[13][9:8] = bus.mtc0_data[9:8];
            5'd14: r[14] = bus.mtc0_data;
            default: ;
          endcase
        end
      end
      for (int i = 0; i < 32; i++) m_reg[k][i] = r[i];
      m_div[k] = d;
    end
  endtask

  task automatic idle();
    bus.mtc0_we = 0; bus.mtc0_addr = 0; bus.mtc0_data = 0; bus.mfc0_addr = 0;
    bus.eret = 0; bus.exception = 0; bus.we_cause = 0; bus.we_epc = 0;
    bus.inc_epc = 0; bus.in_status = 0; bus.in_cause = 0; bus.exc_inst_pc = 0;
    bus.we_badvaddr = 0; bus.bad_vaddr = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.mtc0_we = 1; bus.mtc0_addr = a; bus.mtc0_data = d;
    step();
    bus.mtc0_we = 0;
  endtask

  task automatic test_reset();
    idle(); bus.irq = 0;
    rst = 1; step();
    rst = 0;
    mtc0(5'd12, 32'h0000_FF01);
    rst = 1;
    bus.exception = 1; bus.in_status = 32'h1234_5678;
    bus.mtc0_we = 1; bus.mtc0_addr = 5'd12; bus.mtc0_data = 32'hFFFF_FFFF;
    step();
    rst = 0; idle();
    checks++; if (bus.status !== 32'h0) begin errors++; $display("FAIL reset_status got %h want %h", bus.status, 32'h0); end
    checks++; if (bus.cause !== 32'h0) begin errors++; $display("FAIL reset_cause got %h want %h", bus.cause, 32'h0); end
    checks++; if (bus.epc !== 32'h0) begin errors++; $display("FAIL reset_epc got %h want %h", bus.epc, 32'h0); end
    checks++; if (bus.int_pending !== 1'b0) begin errors++; $display("FAIL reset_int_pending got %b want 0", bus.int_pending); end
    checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL reset_timer_int got %b want 0", bus.timer_int); end
    checks++; if (bus.exc_pc !== 32'h8000_0180) begin errors++; $display("FAIL exc_pc got %h want %h", bus.exc_pc, 32'h8000_0180); end
    bus.mfc0_addr = 5'd11; #1;
    checks++; if (bus.mfc0_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_compare got %h want %h", bus.mfc0_data, 32'hFFFF_FFFF); end
    bus.mfc0_addr = 5'd9; #1;
    checks++; if (bus.mfc0_data !== 32'h0) begin errors++; $display("FAIL reset_count got %h want %h", bus.mfc0_data, 32'h0); end
    checks++; if (bus3.mfc0_data !== 32'h0) begin errors++; $display("FAIL reset_count_div3 got %h want %h", bus3.mfc0_data, 32'h0); end
  endtask

  task automatic test_timer();
    mtc0(5'd9, 32'd5);
    bus.mfc0_addr = 5'd9; #1;
    checks++; if (bus.mfc0_data !== 32'd5) begin errors++; $display("FAIL timer_count_write got %h want %h", bus.mfc0_data, 32'd5); end
    mtc0(5'd11, 32'd8);
    checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL timer_early_6 got %b want 0", bus.timer_int); end
    step();
    checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL timer_early_7 got %b want 0", bus.timer_int); end
    step();
    checks++; if (bus.timer_int !== 1'b1) begin errors++; $display("FAIL timer_match got %b want 1", bus.timer_int); end
    checks++; if (bus.mfc0_data !== 32'd8) begin errors++; $display("FAIL timer_count_8 got %h want %h", bus.mfc0_data, 32'd8); end
    checks++; if (bus3.mfc0_data !== 32'd6) begin errors++; $display("FAIL div3_count got %h want %h", bus3.mfc0_data, 32'd6); end
    step();
    checks++; if (bus.timer_int !== 1'b1) begin errors++; $display("FAIL timer_sticky got %b want 1", bus.timer_int); end
    mtc0(5'd11, 32'd20);
    checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL timer_clear got %b want 0", bus.timer_int); end
    mtc0(5'd11, 32'hFFFF_0000);
  endtask

  task automatic test_exception();
    bus.exception = 1; bus.we_cause = 1; bus.we_epc = 1; bus.inc_epc = 1;
    bus.exc_inst_pc = 32'h0040_0010; bus.in_status = 32'h0000_FF03;
    bus.in_cause = 32'h0000_0024; bus.we_badvaddr = 1; bus.bad_vaddr = 32'hBAD0_0004;
    bus.mtc0_we = 1; bus.mtc0_addr = 5'd14; bus.mtc0_data = 32'hDEAD_BEEF;
    step();
    idle();
    checks++; if (bus.epc !== 32'h0040_000C) begin errors++; $display("FAIL exc_epc_bd got %h want %h", bus.epc, 32'h0040_000C); end
    checks++; if (bus.cause !== 32'h8000_0024) begin errors++; $display("FAIL exc_cause got %h want %h", bus.cause, 32'h8000_0024); end
    checks++; if (bus.status !== 32'h0000_FF03) begin errors++; $display("FAIL exc_status got %h want %h", bus.status, 32'h0000_FF03); end
    bus.mfc0_addr = 5'd8; #1;
    checks++; if (bus.mfc0_data !== 32'hBAD0_0004) begin errors++; $display("FAIL exc_badvaddr got %h want %h", bus.mfc0_data, 32'hBAD0_0004); end
    // Delay-slot fault at PC 0 wraps EPC; Cause itself is not reloaded.
    bus.exception = 1; bus.we_epc = 1; bus.inc_epc = 1; bus.exc_inst_pc = 32'h0;
    bus.in_status = 32'h0000_FF03;
    step();
    idle();
    checks++; if (bus.epc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL exc_epc_wrap got %h want %h", bus.epc, 32'hFFFF_FFFC); end
    bus.exception = 1; bus.we_epc = 1; bus.exc_inst_pc = 32'h0000_0100;
    bus.in_status = 32'h0000_FF03;
    step();
    idle();
    checks++; if (bus.epc !== 32'h0000_0100) begin errors++; $display("FAIL exc_epc_plain got %h want %h", bus.epc, 32'h0000_0100); end
    checks++; if (bus.cause !== 32'h0000_0024) begin errors++; $display("FAIL exc_bd_clear got %h want %h", bus.cause, 32'h0000_0024); end
  endtask

  task automatic test_eret();
    mtc0(5'd12, 32'h0000_0403);
    bus.eret = 1;
    bus.mtc0_we = 1; bus.mtc0_addr = 5'd12; bus.mtc0_data = 32'hFFFF_FFFF;
    step();
    idle();
    checks++; if (bus.status !== 32'h0000_0401) begin errors++; $display("FAIL eret_status got %h want %h", bus.status, 32'h0000_0401); end
    checks++; if (bus.epc !== 32'h0000_0100) begin errors++; $display("FAIL eret_epc got %h want %h", bus.epc, 32'h0000_0100); end
  endtask

  task automatic test_interrupt();
    bus.irq = 5'b00001; #1;
    checks++; if (bus.cause[10] !== 1'b0) begin errors++; $display("FAIL irq_latency got %b want 0", bus.cause[10]); end
    step();
    checks++; if (bus.cause[10] !== 1'b1) begin errors++; $display("FAIL irq_sampled got %b want 1", bus.cause[10]); end
    checks++; if (bus.int_pending !== 1'b1) begin errors++; $display("FAIL int_pending_on got %b want 1", bus.int_pending); end
    mtc0(5'd12, 32'h0000_0403);
    checks++; if (bus.int_pending !== 1'b0) begin errors++; $display("FAIL int_pending_exl got %b want 0", bus.int_pending); end
    mtc0(5'd12, 32'h0000_0401);
    bus.irq = 5'b00000;
    step();
    checks++; if (bus.int_pending !== 1'b0) begin errors++; $display("FAIL int_pending_off got %b want 0", bus.int_pending); end
  endtask

  task automatic test_cause_mask();
    mtc0(5'd13, 32'hFFFF_FFFF);
    checks++; if (bus.cause !== 32'h0000_0324) begin errors++; $display("FAIL cause_mask got %h want %h", bus.cause, 32'h0000_0324); end
    mtc0(5'd8, 32'h1111_1111);
    bus.mfc0_addr = 5'd8; #1;
    checks++; if (bus.mfc0_data !== 32'hBAD0_0004) begin errors++; $display("FAIL badvaddr_ro got %h want %h", bus.mfc0_data, 32'hBAD0_0004); end
    bus.mfc0_addr = 5'd7; #1;
    checks++; if (bus.mfc0_data !== 32'h0) begin errors++; $display("FAIL mfc0_unmapped got %h want %h", bus.mfc0_data, 32'h0); end
    bus.mfc0_addr = 5'd13; #1;
    checks++; if (bus.mfc0_data !== m_reg[0][13]) begin errors++; $display("FAIL mfc0_cause_model got %h want %h", bus.mfc0_data, m_reg[0][13]); end
  endtask

  task automatic test_random();
    logic [4:0] addrs [8] = '{5'd0, 5'd7, 5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    for (int n = 0; n < 400; n++) begin
      idle();
      rst             = ($urandom_range(0, 99) == 0);
      bus.exception   = ($urandom_range(0, 9) == 0);
      bus.we_cause    = 1'($urandom);
      bus.we_epc      = 1'($urandom);
      bus.inc_epc     = 1'($urandom);
      bus.we_badvaddr = 1'($urandom);
      bus.in_status   = $urandom;
      bus.in_cause    = $urandom;
      bus.exc_inst_pc = $urandom;
      bus.bad_vaddr   = $urandom;
      bus.eret        = ($urandom_range(0, 9) == 0);
      bus.mtc0_we     = ($urandom_range(0, 2) == 0);
      bus.mtc0_addr   = addrs[$urandom_range(0, 7)];
      bus.mtc0_data   = $urandom;
      if (bus.mtc0_addr == 5'd11) bus.mtc0_data = m_reg[0][9] + 32'($urandom_range(1, 6));
      if (bus.mtc0_addr == 5'd9)  bus.mtc0_data = m_reg[0][11] - 32'($urandom_range(1, 6));
      bus.irq         = 5'($urandom);
      bus.mfc0_addr   = addrs[$urandom_range(0, 7)];
      step();
      checks++; if (bus.mfc0_data !== m_read(0, bus.mfc0_addr)) begin errors++; $display("FAIL rnd_mfc0 n=%0d reg=%0d got %h want %h", n, bus.mfc0_addr, bus.mfc0_data, m_read(0, bus.mfc0_addr)); end
      checks++; if (bus3.mfc0_data !== m_read(1, bus.mfc0_addr)) begin errors++; $display("FAIL rnd_mfc0_div3 n=%0d reg=%0d got %h want %h", n, bus.mfc0_addr, bus3.mfc0_data, m_read(1, bus.mfc0_addr)); end
      checks++; if (bus.status !== m_reg[0][12]) begin errors++; $display("FAIL rnd_status n=%0d got %h want %h", n, bus.status, m_reg[0][12]); end
      checks++; if (bus.cause !== m_reg[0][13]) begin errors++; $display("FAIL rnd_cause n=%0d got %h want %h", n, bus.cause, m_reg[0][13]); end
      checks++; if (bus3.cause !== m_reg[1][13]) begin errors++; $display("FAIL rnd_cause_div3 n=%0d got %h want %h", n, bus3.cause, m_reg[1][13]); end
      checks++; if (bus.epc !== m_reg[0][14]) begin errors++; $display("FAIL rnd_epc n=%0d got %h want %h", n, bus.epc, m_reg[0][14]); end
      checks++; if (bus.int_pending !== m_int(0)) begin errors++; $display("FAIL rnd_int_pending n=%0d got %b want %b", n, bus.int_pending, m_int(0)); end
      checks++; if (bus.timer_int !== m_reg[0][13][15]) begin errors++; $display("FAIL rnd_timer_int n=%0d got %b want %b", n, bus.timer_int, m_reg[0][13][15]); end
    end
    rst = 0;
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    idle();
    bus.irq = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_timer();
    test_exception();
    test_eret();
    test_interrupt();
    test_cause_mask();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file. It is the receiving end of the exception controller's CP0 write interface (exception, we_cause, we_epc, inc_epc, new status/cause).
- Holds BadVAddr, Count, Compare, Status, Cause and EPC. Serves mfc0/mtc0 and eret from the pipeline.
- Runs the Count/Compare timer and samples external IRQ lines.
- Feeds current Status/Cause back to the exception controller.

Parameters:
- COUNT_DIV, 1: Count increments once every COUNT_DIV cycles (1 = every cycle; legal 1..15).
- EXC_VECTOR, 32'h8000_0180: exception handler address driven on exc_pc.

Ports:
- clk  in  1  clock; every state change happens on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- mtc0_we  in  1  pipeline mtc0 write strobe.
- mtc0_addr  in  5  CP0 register number for mtc0.
- mtc0_data  in  32  mtc0 write data.
- mfc0_addr  in  5  CP0 register number for mfc0.
- mfc0_data  out  32  combinational read data.
- exception  in  1  exception commit from the exception controller.
- we_cause  in  1  load Cause from in_cause on an exception.
- we_epc  in  1  load EPC on an exception.
- inc_epc  in  1  faulting instruction is in a delay slot: EPC = exc_inst_pc-4, Cause.BD=1.
- in_status  in  32  new Status value.
- in_cause  in  32  new Cause value.
- exc_inst_pc  in  32  PC of the faulting instruction.
- we_badvaddr  in  1  load BadVAddr on an exception.
- bad_vaddr  in  32  faulting virtual address.
- eret  in  1  eret commit.
- irq  in  5  external interrupt lines, mapped to Cause.IP[6:2].
- status  out  32  current Status.
- cause  out  32  current Cause.
- epc  out  32  current EPC; this is also the eret target.
- exc_pc  out  32  constant EXC_VECTOR.
- int_pending  out  1  interrupt request to the exception controller.
- timer_int  out  1  Cause.IP7.

Behaviour:
- Register numbers: BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14.
  - mfc0_data returns the register's current value, combinational.
  - Any other register number reads 0.
- Reset values (one cycle of rst):
  - Status, Cause, EPC, BadVAddr, Count = 0.
  - Compare = 32'hFFFF_FFFF.
  - Divider counter = 0.
  - All outputs follow from these values: int_pending=0, timer_int=0.
- Write priority, applied per edge: exception > eret > mtc0. A lower-priority write in the same cycle is dropped entirely.
- Exception (exception=1):
  - Status <= in_status.
  - If we_cause: Cause <= in_cause, except bits [15:10], which keep their hardware value.
  - If we_epc: EPC <= inc_epc ? exc_inst_pc-4 : exc_inst_pc (32-bit wrap). Cause[31] (BD) <= inc_epc.
  - If we_badvaddr: BadVAddr <= bad_vaddr.
- eret (no exception in the same cycle): Status[1] (EXL) <= 0; all other bits are unchanged.
- mtc0 writes:
  - Status: all 32 bits written.
  - Cause: only bits [9:8] (IP1:0) are writable.
  - EPC: full write.
  - Count: full write; the divider counter resets to 0.
  - Compare: full write, and clears IP7 on the same edge.
  - BadVAddr and unmapped registers: ignored.
- Timer:
  - The divider counts 0..COUNT_DIV-1. Count increments (wrapping at 2^32) on the edge where the divider equals COUNT_DIV-1.
  - When the Count value being written by that increment equals Compare, IP7 (Cause[15]) is set on that edge.
  - IP7 stays set until an mtc0 to Compare or reset clears it.
  - A same-edge mtc0 to Count takes precedence over the increment and over the match.
- IRQ: Cause[14:10] <= irq every cycle (registered, one cycle of latency); software cannot write these bits.
- int_pending = Status[0] (IE) & ~Status[1] (EXL) & |(Cause[15:8] & Status[15:8]). Combinational from the registers.
- Reset in mid-operation overrides every write in the same cycle.

Test Plan:
- Reset: apply rst with exception=1 and mtc0_we=1 in the same cycle -> the next cycle reads Status=0, Compare=FFFF_FFFF, Count=0, int_pending=0.
- Timer: COUNT_DIV=1, mtc0 Count=5, Compare=8 -> timer_int rises on the edge where Count becomes 8; mtc0 Compare=20 -> timer_int=0 on the next cycle.
- Exception:
  - exception=1, we_cause, we_epc, inc_epc=1, exc_inst_pc=0x0040_0010, in_status=0x0000_FF03 -> EPC=0x0040_000C, Cause[31]=1, Status=0x0000_FF03.
  - A simultaneous mtc0 to EPC is dropped.
- eret: Status=0x0000_0403, then eret -> Status=0x0000_0401 and epc unchanged.
- Interrupt:
  - Status=0x0000_0401, irq=5'b00001 -> Cause[10]=1 one cycle later and int_pending=1.
  - Set Status.EXL -> int_pending=0.
- mtc0 Cause=0xFFFF_FFFF -> only bits [9:8] change; mfc0 of register 7 returns 0.
